// File: rtl/blockmem_arbiter_if.sv
// rtl/blockmem_arbiter_if.sv - requester, response and blockmem signals of blockmem_arbiter
interface blockmem_arbiter_if #(
   parameter int NREQ  = 2,
   parameter int BITS  = 10,
   parameter int DEPTH = 640
);
   localparam int ADDR_W = $clog2(DEPTH) + 1;

   logic [NREQ-1:0]        req_valid;
   logic [NREQ-1:0]        req_write;
   logic [NREQ*ADDR_W-1:0] req_addr;
   logic [NREQ*BITS-1:0]   req_wdata;
   logic [NREQ-1:0]        req_ready;
   logic [NREQ-1:0]        rsp_valid;
   logic [BITS-1:0]        rsp_rdata;
   logic                   rsp_err;
   logic                   mem_wen;
   logic [ADDR_W-1:0]      mem_waddr;
   logic [BITS-1:0]        mem_wdata;
   logic                   mem_ren;
   logic [ADDR_W-1:0]      mem_raddr;
   logic [BITS-1:0]        mem_rdata;

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, mem_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
             mem_wen, mem_waddr, mem_wdata, mem_ren, mem_raddr
   );

   modport master (
      output req_valid, req_write, req_addr, req_wdata, mem_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
             mem_wen, mem_waddr, mem_wdata, mem_ren, mem_raddr
   );
endinterface

// File: rtl/blockmem_arbiter.sv
// rtl/blockmem_arbiter.sv - round-robin sharing of one blockmem among NREQ requesters
// Write and read ports each have their own arbiter and pointer; read data returns one cycle after grant.
module blockmem_arbiter #(
   parameter int NREQ  = 2,
   parameter int BITS  = 10,
   parameter int DEPTH = 640
) (
   input  logic                clk,
   input  logic                rst_n,
   blockmem_arbiter_if.slave   bus
);
   localparam int ADDR_W = $clog2(DEPTH) + 1;
   localparam int PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
   logic              rsp_err_q, rsp_err_d;

   logic [NREQ-1:0]   wr_cand, rd_cand;
   logic              wr_found, rd_found;
   logic              wr_go, rd_go;
   logic [PTR_W-1:0]  wr_idx, rd_idx;
   logic [ADDR_W-1:0] wr_addr, rd_addr;
   logic              wr_in_range, rd_in_range;

   function automatic logic [PTR_W-1:0] ring_add(input logic [PTR_W-1:0] base, input int step);
      int sum;
      sum = int'(base) + step;
      if (sum >= NREQ) sum = sum - NREQ;
      return PTR_W'(sum);
   endfunction

   // First candidate at or after ptr, searching upward modulo NREQ.
   function automatic void pick(input logic [NREQ-1:0] cand, input logic [PTR_W-1:0] ptr,
                                output logic found, output logic [PTR_W-1:0] idx);
      found = 1'b0;
      idx   = ptr;
      for (int k = 0; k < NREQ; k++) begin
         logic [PTR_W-1:0] c;
         c = ring_add(ptr, k);
         if (!found && cand[c]) begin
            found = 1'b1;
            idx   = c;
         end
      end
   endfunction

   always_comb begin
      wr_cand = bus.req_valid & bus.req_write;
      rd_cand = bus.req_valid & ~bus.req_write;
      pick(wr_cand, wr_ptr_q, wr_found, wr_idx);
      pick(rd_cand, rd_ptr_q, rd_found, rd_idx);

      wr_go       = wr_found & rst_n;
      rd_go       = rd_found & rst_n;
      wr_addr     = bus.req_addr[wr_idx*ADDR_W +: ADDR_W];
      rd_addr     = bus.req_addr[rd_idx*ADDR_W +: ADDR_W];
      wr_in_range = (wr_addr < DEPTH_A);
      rd_in_range = (rd_addr < DEPTH_A);

      bus.req_ready = '0;
      if (wr_go) bus.req_ready[wr_idx] = 1'b1;
      if (rd_go) bus.req_ready[rd_idx] = 1'b1;

      // Out-of-range accesses are granted but never reach the memory.
      bus.mem_wen   = wr_go & wr_in_range;
      bus.mem_waddr = wr_addr;
      bus.mem_wdata = bus.req_wdata[wr_idx*BITS +: BITS];
      bus.mem_ren   = rd_go & rd_in_range;
      bus.mem_raddr = rd_addr;

      wr_ptr_d = wr_go ? ring_add(wr_idx, 1) : wr_ptr_q;
      rd_ptr_d = rd_go ? ring_add(rd_idx, 1) : rd_ptr_q;

      rsp_valid_d = '0;
      if (rd_go) rsp_valid_d[rd_idx] = 1'b1;
      rsp_err_d = rd_go & ~rd_in_range;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         rsp_valid_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_rdata = rsp_err_q ? '0 : bus.mem_rdata;
endmodule

// File: tb/tb_blockmem_arbiter.sv
// tb/tb_blockmem_arbiter.sv - directed and random checks of blockmem_arbiter against a reference model
module tb_blockmem_arbiter;
   localparam int BITS  = 10;
   localparam int DEPTH = 640;
   localparam int AW    = $clog2(DEPTH) + 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   blockmem_arbiter_if #(.NREQ(2), .BITS(BITS), .DEPTH(DEPTH)) b2 ();
   blockmem_arbiter_if #(.NREQ(3), .BITS(BITS), .DEPTH(DEPTH)) b3 ();

   blockmem_arbiter #(.NREQ(2), .BITS(BITS), .DEPTH(DEPTH)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));
   blockmem_arbiter #(.NREQ(3), .BITS(BITS), .DEPTH(DEPTH)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));

   // Blockmem stand-ins: registered read, read-before-write on a shared address.
   bit [BITS-1:0] bm2 [DEPTH];
   bit [BITS-1:0] bm3 [DEPTH];
   always @(posedge clk) begin
      if (b2.mem_ren) b2.mem_rdata <= bm2[b2.mem_raddr];
      if (b2.mem_wen) bm2[b2.mem_waddr] <= b2.mem_wdata;
      if (b3.mem_ren) b3.mem_rdata <= bm3[b3.mem_raddr];
      if (b3.mem_wen) bm3[b3.mem_waddr] <= b3.mem_wdata;
   end

   int ref2 [DEPTH];
   int ref3 [DEPTH];
   bit [1:0] v2, w2;
   int       a2 [2];
   int       d2 [2];
   int       wp2, rp2;
   bit [2:0] v3, w3;
   int       a3 [3];
   int       d3 [3];
   int       errors = 0;
   int       checks = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive2();
      b2.req_valid = v2;
      b2.req_write = w2;
      b2.req_addr  = {AW'(a2[1]), AW'(a2[0])};
      b2.req_wdata = {BITS'(d2[1]), BITS'(d2[0])};
   endtask

   task automatic drive3();
      b3.req_valid = v3;
      b3.req_write = w3;
      b3.req_addr  = {AW'(a3[2]), AW'(a3[1]), AW'(a3[0])};
      b3.req_wdata = {BITS'(d3[2]), BITS'(d3[1]), BITS'(d3[0])};
   endtask

   function automatic int first_at(input bit [3:0] cand, input int ptr, input int n);
      for (int k = 0; k < n; k++)
         if (cand[(ptr + k) % n]) return (ptr + k) % n;
      return -1;
   endfunction

   task automatic new_req2(input int i);
      v2[i] = ($urandom_range(0, 3) != 0);
      w2[i] = ($urandom_range(0, 1) == 1);
      a2[i] = ($urandom_range(0, 9) == 0) ? int'(640 + $urandom_range(0, 7)) : int'($urandom_range(0, 15));
      d2[i] = int'($urandom_range(0, 1023));
   endtask

   // One cycle on the 2-requester instance; called at a negedge, returns at the next negedge.
   task automatic cycle2(input string tag, output bit [1:0] gnt);
      int       wg, rg, exp_data;
      bit       wen_e, ren_e, exp_err;
      bit [1:0] exp_rdy, exp_rv;
      drive2();
      #2;
      wg = first_at(4'(v2 & w2), wp2, 2);
      rg = first_at(4'(v2 & ~w2), rp2, 2);
      exp_rdy = '0;
      wen_e = 1'b0;
      ren_e = 1'b0;
      if (wg >= 0) begin exp_rdy[wg] = 1'b1; wen_e = (a2[wg] < DEPTH); end
      if (rg >= 0) begin exp_rdy[rg] = 1'b1; ren_e = (a2[rg] < DEPTH); end
      check({tag, ".rdy"}, 32'(b2.req_ready), 32'(exp_rdy));
      check({tag, ".wen"}, 32'(b2.mem_wen), 32'(wen_e));
      check({tag, ".ren"}, 32'(b2.mem_ren), 32'(ren_e));
      if (wen_e) begin
         check({tag, ".waddr"}, 32'(b2.mem_waddr), a2[wg]);
         check({tag, ".wdata"}, 32'(b2.mem_wdata), d2[wg]);
      end
      if (ren_e) check({tag, ".raddr"}, 32'(b2.mem_raddr), a2[rg]);
      exp_rv = '0;
      exp_err = 1'b0;
      exp_data = 0;
      if (rg >= 0) begin
         exp_rv[rg] = 1'b1;
         exp_err = !ren_e;
         exp_data = exp_err ? 0 : ref2[a2[rg]];
      end
      if (wen_e) ref2[a2[wg]] = d2[wg];
      if (wg >= 0) wp2 = (wg + 1) % 2;
      if (rg >= 0) rp2 = (rg + 1) % 2;
      gnt = exp_rdy;
      @(posedge clk);
      #2;
      check({tag, ".rsp_valid"}, 32'(b2.rsp_valid), 32'(exp_rv));
      check({tag, ".rsp_err"}, 32'(b2.rsp_err), 32'(exp_err));
      if (exp_rv != 0) check({tag, ".rsp_rdata"}, 32'(b2.rsp_rdata), exp_data);
      @(negedge clk);
   endtask

   initial begin
      bit [1:0] g;
      int       waited [3];
      int       max_wait, resp_cnt, gi, exp_data;

      wp2 = 0; rp2 = 0;
      v2 = 2'b11; w2 = 2'b01; a2[0] = 3; a2[1] = 4; d2[0] = 7; d2[1] = 8;
      v3 = 3'b111; w3 = 3'b010; a3[0] = 1; a3[1] = 2; a3[2] = 3; d3[0] = 1; d3[1] = 2; d3[2] = 3;
      drive2();
      drive3();
      #2;
      check("reset.rdy2", 32'(b2.req_ready), 0);
      check("reset.wen2", 32'(b2.mem_wen), 0);
      check("reset.ren2", 32'(b2.mem_ren), 0);
      check("reset.rsp_valid2", 32'(b2.rsp_valid), 0);
      check("reset.rsp_err2", 32'(b2.rsp_err), 0);
      check("reset.rdy3", 32'(b3.req_ready), 0);
      check("reset.rsp_valid3", 32'(b3.rsp_valid), 0);
      v3 = '0;
      drive3();
      @(negedge clk);
      rst_n = 1'b1;

      // Both requesters write for six cycles: strict alternation starting at req0.
      v2 = 2'b11; w2 = 2'b11;
      for (int k = 0; k < 6; k++) begin
         a2[0] = 100 + k; a2[1] = 200 + k;
         d2[0] = int'($urandom_range(0, 1023)); d2[1] = int'($urandom_range(0, 1023));
         cycle2("t2", g);
         check("t2.order", 32'(g), (k % 2 == 0) ? 32'd1 : 32'd2);
      end

      v2 = 2'b01; w2 = 2'b01; a2[0] = 5; d2[0] = 'h2A;
      cycle2("t1.wr", g);
      w2 = 2'b00;
      cycle2("t1.rd", g);

      v2 = 2'b01; w2 = 2'b01; a2[0] = 9; d2[0] = 'h003;
      cycle2("t3.pre", g);
      v2 = 2'b11; w2 = 2'b01; a2[0] = 9; d2[0] = 'h155; a2[1] = 9;
      cycle2("t3.hazard", g);
      check("t3.both_rdy", 32'(g), 3);
      v2 = 2'b10; w2 = 2'b00;
      cycle2("t3.reread", g);

      v2 = 2'b10; w2 = 2'b10; a2[1] = 640; d2[1] = 'h3FF;
      cycle2("t4.wr", g);
      w2 = 2'b00;
      cycle2("t4.rd", g);

      new_req2(0);
      new_req2(1);
      for (int c = 0; c < 150; c++) begin
         cycle2("rnd", g);
         for (int i = 0; i < 2; i++)
            if (g[i] || !v2[i]) new_req2(i);
      end

      // Reset lands between a read grant and its response edge.
      v2 = 2'b01; w2 = 2'b00; a2[0] = 5;
      cycle2("t5.pre", g);
      drive2();
      #2;
      check("t5.rdy", 32'(b2.req_ready), 1);
      #1 rst_n = 1'b0;
      #1;
      check("t5.rdy_in_reset", 32'(b2.req_ready), 0);
      check("t5.ren_in_reset", 32'(b2.mem_ren), 0);
      #2 rst_n = 1'b1;
      #1;
      check("t5.no_rsp", 32'(b2.rsp_valid), 0);
      check("t5.no_err", 32'(b2.rsp_err), 0);
      wp2 = 0; rp2 = 0;
      @(negedge clk);
      v2 = 2'b11; w2 = 2'b00; a2[1] = 9;
      cycle2("t5.after", g);
      check("t5.first_req0", 32'(g), 1);
      v2 = 2'b00;
      drive2();

      for (int j = 0; j < 8; j++) begin
         v3 = 3'b001; w3 = 3'b001; a3[0] = j; d3[0] = int'($urandom_range(0, 1023));
         drive3();
         #2;
         check("t6.pre.rdy", 32'(b3.req_ready), 1);
         check("t6.pre.wen", 32'(b3.mem_wen), 1);
         ref3[j] = d3[0];
         @(negedge clk);
      end

      // Three continuous readers: grants rotate 0,1,2 and each waits exactly two cycles.
      v3 = 3'b111; w3 = 3'b000;
      for (int i = 0; i < 3; i++) begin
         a3[i] = int'($urandom_range(0, 7));
         waited[i] = 0;
      end
      max_wait = 0;
      resp_cnt = 0;
      for (int c = 0; c < 30; c++) begin
         gi = c % 3;
         drive3();
         #2;
         check("t6.rdy", 32'(b3.req_ready), 32'(1 << gi));
         check("t6.ren", 32'(b3.mem_ren), 1);
         check("t6.raddr", 32'(b3.mem_raddr), a3[gi]);
         for (int i = 0; i < 3; i++) begin
            if (b3.req_ready[i]) waited[i] = 0;
            else begin
               waited[i]++;
               if (waited[i] > max_wait) max_wait = waited[i];
            end
         end
         exp_data = ref3[a3[gi]];
         @(posedge clk);
         #2;
         check("t6.rsp_valid", 32'(b3.rsp_valid), 32'(1 << gi));
         check("t6.rsp_err", 32'(b3.rsp_err), 0);
         check("t6.rsp_rdata", 32'(b3.rsp_rdata), exp_data);
         if (b3.rsp_valid === 3'(1 << gi)) resp_cnt++;
         a3[gi] = int'($urandom_range(0, 7));
         @(negedge clk);
      end
      check("t6.resp_cnt", resp_cnt, 30);
      check("t6.max_wait", max_wait, 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
